// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M multiply/divide unit.
// Operands are reduced to magnitudes on acceptance. One shift-add (multiply)
// or one shift-subtract (restoring divide) step runs per clock, and the sign
// is reapplied on the final step. Divide-by-zero and signed overflow finish
// in a single cycle with the RISC-V defined results.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW      = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Latched operation context; acc holds {hi, lo} of the product, or
  // {remainder, dividend/quotient} while dividing.
  logic [2:0]        op_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_q;
  logic [CW-1:0]     count_q;

  logic              accept;
  logic              last_iter;
  logic              signed_a;
  logic              signed_b;
  logic              sign_a;
  logic              sign_b;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic              neg_in;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   special_value;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   remd;
  logic [XLEN-1:0]   final_value;

  // Decode the incoming request: signedness, magnitudes and short-cut results.
  always_comb begin
    accept        = start && ((state == IDLE) || (state == DONE));
    signed_a      = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    signed_b      = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    sign_a        = signed_a && a[XLEN-1];
    sign_b        = signed_b && b[XLEN-1];
    mag_a         = sign_a ? -a : a;
    mag_b         = sign_b ? -b : b;
    neg_in        = (op[2] && op[1]) ? sign_a : (sign_a ^ sign_b);
    div_zero      = op[2] && (b == '0);
    div_ovf       = ((op == 3'b100) || (op == 3'b110)) && (a == MIN_INT) && (b == '1);
    special       = div_zero || div_ovf;
    special_value = '0;
    if (div_zero) begin
      special_value = op[1] ? a : '1;
    end else begin
      special_value = op[1] ? '0 : a;
    end
  end

  // One radix-2 iteration: shift-add for multiply, shift-subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    acc_next  = acc_q;
    if (op_q[2]) begin
      if (!div_diff[XLEN]) begin
        acc_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc_q[XLEN-1:1]};
    end
    last_iter = (count_q == LAST);
  end

  // Reapply the sign to the outcome of the final iteration and select the field.
  always_comb begin
    prod_signed = neg_q ? -acc_next : acc_next;
    quot        = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    remd        = neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    final_value = '0;
    case (op_q)
      3'b000:         final_value = prod_signed[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         final_value = prod_signed[2*XLEN-1:XLEN];
      3'b100, 3'b101: final_value = quot;
      default:        final_value = remd;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs decoded from the registered state.
  always_comb begin
    state_next = state;
    busy       = (state == CALC);
    done       = (state == DONE);
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_next = special ? DONE : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture on acceptance, iteration while calculating, result write on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
      result  <= '0;
    end else if (accept) begin
      op_q    <= op;
      neg_q   <= neg_in;
      count_q <= '0;
      if (op[2]) begin
        opnd_q <= mag_b;
        acc_q  <= {{XLEN{1'b0}}, mag_a};
      end else begin
        opnd_q <= mag_a;
        acc_q  <= {{XLEN{1'b0}}, mag_b};
      end
      if (special) begin
        result <= special_value;
      end
    end else if (state == CALC) begin
      acc_q   <= acc_next;
      count_q <= count_q + CW'(1);
      if (last_iter) begin
        result <= final_value;
      end
    end
  end

endmodule
